// File: rtl/camera_pkg.sv
// camera_pkg: shared opcodes, capture FSM states and status bit positions
package camera_pkg;
  localparam logic [7:0] OP_CAPTURE  = 8'h20;
  localparam logic [7:0] OP_READ     = 8'h22;
  localparam logic [7:0] OP_SET_ADDR = 8'h23;
  localparam logic [7:0] OP_WINDOW   = 8'h24;
  localparam logic [7:0] OP_FORMAT   = 8'h30;
  localparam logic [7:0] OP_IMG_SIZE = 8'h31;
  localparam logic [7:0] OP_STATUS   = 8'h32;
  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_WAIT_SOF, ST_ACTIVE} cap_state_t;
  localparam int STAT_BUSY       = 0;
  localparam int STAT_IMG_VALID  = 1;
  localparam int STAT_ERR_BUSY   = 2;
  localparam int STAT_ERR_WINDOW = 3;
endpackage

// File: rtl/image_capture_ctrl_sync_2ff.sv
// sync_2ff: two-flop synchroniser with asynchronous active-low reset
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, meta} <= 2'b00;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/image_capture_ctrl.sv
// image_capture_ctrl: host-command driven capture FSM, crop window, image buffer readout
module image_capture_ctrl
  import camera_pkg::*;
#(
  parameter int SENSOR_X_SIZE = 1280,
  parameter int SENSOR_Y_SIZE = 720,
  parameter int ADDR_BITS     = 16
) (
  input  logic                 clock_spi_in,
  input  logic                 reset_spi_n_in,
  input  logic [7:0]           op_code_in,
  input  logic                 op_code_valid_in,
  input  logic [7:0]           operand_in,
  input  logic                 operand_valid_in,
  input  logic [31:0]          operand_count_in,
  output logic [7:0]           response_out,
  output logic                 response_valid_out,
  input  logic                 frame_valid_in,
  input  logic [19:0]          image_size_in,
  input  logic                 image_valid_in,
  input  logic [7:0]           read_data_in,
  output logic [ADDR_BITS-1:0] read_address_out,
  output logic                 capture_start_out,
  output logic                 buffer_clear_out,
  output logic [10:0]          x_crop_start_out,
  output logic [10:0]          x_crop_end_out,
  output logic [9:0]           y_crop_start_out,
  output logic [9:0]           y_crop_end_out,
  output logic [10:0]          x_size_out,
  output logic [9:0]           y_size_out,
  output logic                 jpeg_sel_out,
  output logic                 busy_out
);
  localparam int AW = ADDR_BITS > 16 ? ADDR_BITS : 16;
  cap_state_t state;
  logic fv_s, op_vld_d, opd_vld_d, err_busy, err_window;
  logic [7:0] op_last;
  logic [15:0] st_xs, st_xe, st_ys, st_ye;
  logic op_rise, op_fall, opd_rise, is_idle, wr, cap_req, cap_go, win_ok, rsp_we;
  logic [7:0] img_byte, status, rsp_next;
  logic [AW-1:0] addr_ext;
  logic [ADDR_BITS-1:0] addr_set, addr_inc;
  sync_2ff u_fv_sync (
    .clk  (clock_spi_in),
    .rst_n(reset_spi_n_in),
    .d    (frame_valid_in),
    .q    (fv_s)
  );
  assign busy_out   = state != ST_IDLE;
  assign x_size_out = x_crop_end_out - x_crop_start_out - 11'd2;
  assign y_size_out = y_crop_end_out - y_crop_start_out - 10'd2;
  always_comb begin
    op_rise  = op_code_valid_in & ~op_vld_d;
    op_fall  = ~op_code_valid_in & op_vld_d;
    opd_rise = operand_valid_in & ~opd_vld_d;
    is_idle  = state == ST_IDLE;
    wr       = op_code_valid_in & operand_valid_in;
    cap_req  = op_rise && op_code_in == OP_CAPTURE;
    cap_go   = (is_idle && cap_req && !fv_s) || (state == ST_ARM && !fv_s);
    win_ok   = 32'(st_xe) >= 32'(st_xs) + 32'd4 && 32'(st_ye) >= 32'(st_ys) + 32'd4 &&
               32'(st_xe) <= 32'(SENSOR_X_SIZE) && 32'(st_ye) <= 32'(SENSOR_Y_SIZE) && is_idle;
    img_byte = !image_valid_in ? 8'h00 :
               operand_count_in == 32'd0 ? image_size_in[7:0] :
               operand_count_in == 32'd1 ? image_size_in[15:8] :
               operand_count_in == 32'd2 ? {4'h0, image_size_in[19:16]} : 8'h00;
    status = '0;
    status[STAT_BUSY]       = busy_out;
    status[STAT_IMG_VALID]  = image_valid_in;
    status[STAT_ERR_BUSY]   = err_busy;
    status[STAT_ERR_WINDOW] = err_window;
    rsp_next = op_code_in == OP_IMG_SIZE ? img_byte : op_code_in == OP_STATUS ? status : read_data_in;
    rsp_we   = op_code_valid_in && (op_code_in == OP_IMG_SIZE || op_code_in == OP_STATUS ||
               (op_code_in == OP_READ && opd_rise));
    addr_ext = AW'(read_address_out);
    if (operand_count_in == 32'd0) addr_ext[7:0] = operand_in;
    if (operand_count_in == 32'd1) addr_ext[15:8] = operand_in;
    addr_set = ADDR_BITS'(addr_ext);
    addr_inc = &read_address_out ? read_address_out : read_address_out + 1'b1;
  end
  always_ff @(posedge clock_spi_in or negedge reset_spi_n_in)
    if (!reset_spi_n_in) begin
      state              <= ST_IDLE;
      op_vld_d           <= 1'b0;
      opd_vld_d          <= 1'b0;
      op_last            <= 8'h00;
      capture_start_out  <= 1'b0;
      buffer_clear_out   <= 1'b0;
      response_out       <= 8'h00;
      response_valid_out <= 1'b0;
      read_address_out   <= '0;
      jpeg_sel_out       <= 1'b1;
      err_busy           <= 1'b0;
      err_window         <= 1'b0;
      x_crop_start_out   <= '0;
      x_crop_end_out     <= 11'(SENSOR_X_SIZE);
      y_crop_start_out   <= '0;
      y_crop_end_out     <= 10'(SENSOR_Y_SIZE);
      st_xs              <= '0;
      st_xe              <= 16'(SENSOR_X_SIZE);
      st_ys              <= '0;
      st_ye              <= 16'(SENSOR_Y_SIZE);
    end else begin
      op_vld_d           <= op_code_valid_in;
      opd_vld_d          <= operand_valid_in;
      capture_start_out  <= cap_go;
      buffer_clear_out   <= cap_go;
      response_valid_out <= op_code_valid_in &&
                            (op_code_in == OP_READ || op_code_in == OP_IMG_SIZE || op_code_in == OP_STATUS);
      if (op_code_valid_in) op_last <= op_code_in;
      case (state)
        ST_IDLE:     if (cap_req) state <= fv_s ? ST_ARM : ST_WAIT_SOF;
        ST_ARM:      if (!fv_s) state <= ST_WAIT_SOF;
        ST_WAIT_SOF: if (fv_s) state <= ST_ACTIVE;
        default:     if (!fv_s) state <= ST_IDLE;
      endcase
      if (op_fall && op_last == OP_STATUS) {err_window, err_busy} <= 2'b00;
      if (cap_req && !is_idle) err_busy <= 1'b1;
      if (op_fall && op_last == OP_WINDOW) begin
        if (win_ok) begin
          x_crop_start_out <= st_xs[10:0];
          x_crop_end_out   <= st_xe[10:0];
          y_crop_start_out <= st_ys[9:0];
          y_crop_end_out   <= st_ye[9:0];
        end else err_window <= 1'b1;
      end
      if (wr && op_code_in == OP_WINDOW)
        case (operand_count_in)
          32'd0:   st_xs[7:0]  <= operand_in;
          32'd1:   st_xs[15:8] <= operand_in;
          32'd2:   st_xe[7:0]  <= operand_in;
          32'd3:   st_xe[15:8] <= operand_in;
          32'd4:   st_ys[7:0]  <= operand_in;
          32'd5:   st_ys[15:8] <= operand_in;
          32'd6:   st_ye[7:0]  <= operand_in;
          32'd7:   st_ye[15:8] <= operand_in;
          default: ;
        endcase
      if (wr && op_code_in == OP_FORMAT && is_idle) jpeg_sel_out <= ~operand_in[0];
      if (rsp_we) response_out <= rsp_next;
      if (op_code_valid_in && op_code_in == OP_READ && opd_rise) read_address_out <= addr_inc;
      if (wr && op_code_in == OP_SET_ADDR) read_address_out <= addr_set;
      if (cap_go) read_address_out <= '0;
    end
endmodule

// File: tb/tb_image_capture_ctrl.sv
// tb_image_capture_ctrl: randomized host traffic checked against a behavioural model
module tb_image_capture_ctrl;
  import camera_pkg::*;
  localparam int XS = 1280;
  localparam int YS = 720;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] op_code_in = '0, operand_in = '0, response_out, read_data_in;
  logic op_code_valid_in = 1'b0, operand_valid_in = 1'b0, response_valid_out;
  logic [31:0] operand_count_in = '0;
  logic frame_valid_in = 1'b0, image_valid_in = 1'b0;
  logic [19:0] image_size_in = '0;
  logic [15:0] read_address_out;
  logic capture_start_out, buffer_clear_out, jpeg_sel_out, busy_out;
  logic [10:0] x_crop_start_out, x_crop_end_out, x_size_out;
  logic [9:0] y_crop_start_out, y_crop_end_out, y_size_out;
  int checks = 0, failures = 0;
  int m_xs, m_xe, m_ys, m_ye;
  logic m_jpeg, m_busy, m_err_busy, m_err_win;
  logic [15:0] m_addr;
  bit chk_en = 0, lit_on = 0;
  logic [7:0] obuf[8];
  logic [7:0] lit_exp[8];
  always #5 clk = ~clk;
  function automatic logic [7:0] mem_f(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction
  assign read_data_in = mem_f(read_address_out);
  image_capture_ctrl dut (
    .clock_spi_in(clk), .reset_spi_n_in(rst_n),
    .op_code_in(op_code_in), .op_code_valid_in(op_code_valid_in),
    .operand_in(operand_in), .operand_valid_in(operand_valid_in),
    .operand_count_in(operand_count_in),
    .response_out(response_out), .response_valid_out(response_valid_out),
    .frame_valid_in(frame_valid_in), .image_size_in(image_size_in),
    .image_valid_in(image_valid_in), .read_data_in(read_data_in),
    .read_address_out(read_address_out),
    .capture_start_out(capture_start_out), .buffer_clear_out(buffer_clear_out),
    .x_crop_start_out(x_crop_start_out), .x_crop_end_out(x_crop_end_out),
    .y_crop_start_out(y_crop_start_out), .y_crop_end_out(y_crop_end_out),
    .x_size_out(x_size_out), .y_size_out(y_size_out),
    .jpeg_sel_out(jpeg_sel_out), .busy_out(busy_out)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_xs = 0; m_xe = XS; m_ys = 0; m_ye = YS;
    m_jpeg = 1'b1; m_busy = 1'b0; m_err_busy = 1'b0; m_err_win = 1'b0; m_addr = '0;
  endtask
  always @(negedge clk)
    if (chk_en && rst_n) begin
      chk("x_start", 32'(x_crop_start_out), m_xs);
      chk("x_end", 32'(x_crop_end_out), m_xe);
      chk("y_start", 32'(y_crop_start_out), m_ys);
      chk("y_end", 32'(y_crop_end_out), m_ye);
      chk("x_size", 32'(x_size_out), m_xe - m_xs - 2);
      chk("y_size", 32'(y_size_out), m_ye - m_ys - 2);
      chk("jpeg_sel", 32'(jpeg_sel_out), 32'(m_jpeg));
      chk("busy", 32'(busy_out), 32'(m_busy));
      chk("rd_addr_idle", 32'(read_address_out), 32'(m_addr));
      chk("rsp_valid_idle", 32'(response_valid_out), 0);
      chk("cap_start_idle", 32'(capture_start_out), 0);
      chk("buf_clear_idle", 32'(buffer_clear_out), 0);
    end
  task automatic fill_win(input int xs, input int xe, input int ys, input int ye);
    {obuf[1], obuf[0]} = 16'(xs);
    {obuf[3], obuf[2]} = 16'(xe);
    {obuf[5], obuf[4]} = 16'(ys);
    {obuf[7], obuf[6]} = 16'(ye);
  endtask
  task automatic xact(input logic [7:0] op, input int n);
    logic [7:0] e;
    logic [23:0] isz;
    int xs, xe, ys, ye;
    chk_en = 0;
    @(posedge clk); #1;
    op_code_in = op; op_code_valid_in = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      operand_in = obuf[i]; operand_count_in = i; operand_valid_in = 1'b1;
      e = mem_f(m_addr);
      @(posedge clk); #1;
      operand_valid_in = 1'b0;
      chk("rsp_valid", 32'(response_valid_out), 32'(op == OP_READ || op == OP_IMG_SIZE || op == OP_STATUS));
      if (lit_on) chk("lit_rsp", 32'(response_out), 32'(lit_exp[i]));
      if (op == OP_READ) begin
        chk("rd_data", 32'(response_out), 32'(e));
        m_addr = m_addr == 16'hFFFF ? m_addr : m_addr + 16'd1;
        chk("rd_addr_step", 32'(read_address_out), 32'(m_addr));
      end
      if (op == OP_IMG_SIZE) begin
        isz = image_valid_in ? {4'h0, image_size_in} : 24'd0;
        chk("img_byte", 32'(response_out), i < 3 ? 32'(isz[8*i +: 8]) : 32'd0);
      end
      if (op == OP_STATUS)
        chk("status", 32'(response_out), 32'({4'h0, m_err_win, m_err_busy, image_valid_in, m_busy}));
      if (op == OP_SET_ADDR && i == 0) m_addr[7:0] = obuf[i];
      if (op == OP_SET_ADDR && i == 1) m_addr[15:8] = obuf[i];
      if (op == OP_FORMAT && !m_busy) m_jpeg = ~obuf[i][0];
      @(posedge clk); #1;
    end
    op_code_valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (op == OP_WINDOW) begin
      xs = int'({obuf[1], obuf[0]}); xe = int'({obuf[3], obuf[2]});
      ys = int'({obuf[5], obuf[4]}); ye = int'({obuf[7], obuf[6]});
      if (xe >= xs + 4 && ye >= ys + 4 && xe <= XS && ye <= YS && !m_busy) begin
        m_xs = xs; m_xe = xe; m_ys = ys; m_ye = ye;
      end else m_err_win = 1'b1;
    end
    if (op == OP_STATUS) begin m_err_busy = 1'b0; m_err_win = 1'b0; end
    if (op == OP_CAPTURE && m_busy) m_err_busy = 1'b1;
    chk_en = 1;
  endtask
  task automatic start_cap(input bit fv0);
    bit seen;
    int k;
    chk_en = 0;
    frame_valid_in = fv0;
    repeat (4) @(posedge clk);
    #1;
    op_code_in = OP_CAPTURE; op_code_valid_in = 1'b1;
    @(posedge clk); #1;
    op_code_valid_in = 1'b0;
    chk("cap_busy", 32'(busy_out), 1);
    chk("cap_start", 32'(capture_start_out), 32'(!fv0));
    chk("cap_clear", 32'(buffer_clear_out), 32'(!fv0));
    if (fv0) begin
      frame_valid_in = 1'b0; seen = 0; k = 0;
      while (!seen && k < 6) begin
        @(posedge clk); #1;
        k++;
        seen = capture_start_out && buffer_clear_out;
      end
      chk("arm_pulse_seen", 32'(seen), 1);
      chk("arm_pulse_within_3", 32'(k <= 3), 1);
    end
    chk("cap_addr_zero", 32'(read_address_out), 0);
    m_addr = '0; m_busy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1;
  endtask
  task automatic mid_op(input int kind);
    case (kind)
      0: xact(OP_CAPTURE, 0);
      1: begin fill_win(8, 200, 4, 100); xact(OP_WINDOW, 8); end
      2: begin obuf[0] = 8'($urandom); xact(OP_FORMAT, 1); end
      default: begin obuf[0] = 8'h00; xact(OP_STATUS, 1); end
    endcase
  endtask
  task automatic end_cap(input int mid);
    if (mid >= 0) mid_op(mid);
    frame_valid_in = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    if (mid >= 0) mid_op(mid);
    chk_en = 0;
    frame_valid_in = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    m_busy = 1'b0;
    chk("cap_done_busy", 32'(busy_out), 0);
    chk_en = 1;
  endtask
  initial begin
    logic [15:0] lit_addr[4];
    int kind, xs, ys;
    lit_addr = '{16'hFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy_out), 0);
    chk("rst_jpeg", 32'(jpeg_sel_out), 1);
    chk("rst_x_end", 32'(x_crop_end_out), 1280);
    chk("rst_y_end", 32'(y_crop_end_out), 720);
    chk("rst_addr", 32'(read_address_out), 0);
    chk("rst_cap", 32'(capture_start_out), 0);
    rst_n = 1'b1;
    chk_en = 1;
    start_cap(0);
    end_cap(-1);
    start_cap(1);
    end_cap(0);
    obuf[0] = 8'h00;
    xact(OP_STATUS, 1);
    fill_win(8, 200, 4, 100);
    xact(OP_WINDOW, 8);
    chk("lit_x_size", 32'(x_size_out), 190);
    chk("lit_y_size", 32'(y_size_out), 94);
    fill_win(8, 1281, 4, 100);
    xact(OP_WINDOW, 8);
    chk("lit_x_end_kept", 32'(x_crop_end_out), 200);
    obuf[0] = 8'h00;
    xact(OP_STATUS, 1);
    chk("lit_err_window_set", 32'(response_out[3]), 1);
    xact(OP_STATUS, 1);
    chk("lit_err_window_clr", 32'(response_out[3]), 0);
    fill_win(0, 4, 0, 4);
    xact(OP_WINDOW, 8);
    fill_win(0, 3, 0, 4);
    xact(OP_WINDOW, 8);
    fill_win(1276, 1280, 716, 720);
    xact(OP_WINDOW, 8);
    fill_win(0, 1280, 0, 721);
    xact(OP_WINDOW, 8);
    obuf[0] = 8'hFE; obuf[1] = 8'hFF;
    xact(OP_SET_ADDR, 2);
    for (int i = 0; i < 4; i++) begin
      chk("lit_addr", 32'(read_address_out), 32'(lit_addr[i]));
      xact(OP_READ, 1);
    end
    image_size_in = 20'h12345; image_valid_in = 1'b1;
    lit_exp[0] = 8'h45; lit_exp[1] = 8'h23; lit_exp[2] = 8'h01; lit_on = 1;
    xact(OP_IMG_SIZE, 3);
    image_valid_in = 1'b0;
    lit_exp[0] = 8'h00; lit_exp[1] = 8'h00; lit_exp[2] = 8'h00;
    xact(OP_IMG_SIZE, 3);
    lit_on = 0;
    obuf[0] = 8'h11; obuf[1] = 8'h22;
    xact(8'h55, 2);
    obuf[0] = 8'h01;
    xact(OP_FORMAT, 1);
    chk("lit_rgb_sel", 32'(jpeg_sel_out), 0);
    for (int it = 0; it < 80; it++) begin
      kind = int'($urandom_range(0, 7));
      case (kind)
        0: begin
          if ($urandom_range(0, 1) == 1) begin
            xs = int'($urandom_range(0, 1276)); ys = int'($urandom_range(0, 716));
            fill_win(xs, int'($urandom_range(xs + 4, 1280)), ys, int'($urandom_range(ys + 4, 720)));
          end else
            fill_win(int'($urandom_range(0, 1300)), int'($urandom_range(0, 1300)),
                     int'($urandom_range(0, 750)), int'($urandom_range(0, 750)));
          xact(OP_WINDOW, 8);
        end
        1: begin obuf[0] = 8'($urandom); xact(OP_FORMAT, 1); end
        2: begin
          image_size_in = 20'($urandom); image_valid_in = 1'($urandom_range(0, 1));
          xact(OP_IMG_SIZE, int'($urandom_range(1, 3)));
        end
        3: begin image_valid_in = 1'($urandom_range(0, 1)); obuf[0] = 8'h00; xact(OP_STATUS, 1); end
        4: begin
          obuf[0] = 8'($urandom);
          obuf[1] = $urandom_range(0, 1) == 1 ? 8'hFF : 8'($urandom);
          xact(OP_SET_ADDR, 2);
        end
        5: xact(OP_READ, int'($urandom_range(1, 5)));
        6: begin start_cap(1'($urandom_range(0, 1))); end_cap(int'($urandom_range(0, 4)) - 1); end
        default: begin obuf[0] = 8'($urandom); xact(8'h40 + 8'($urandom_range(0, 15)), 1); end
      endcase
    end
    fill_win(8, 200, 4, 100);
    xact(OP_WINDOW, 8);
    obuf[0] = 8'h01;
    xact(OP_FORMAT, 1);
    start_cap(0);
    frame_valid_in = 1'b1;
    repeat (5) @(posedge clk);
    chk_en = 0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy_out), 0);
    chk("rst_mid_jpeg", 32'(jpeg_sel_out), 1);
    chk("rst_mid_x_start", 32'(x_crop_start_out), 0);
    chk("rst_mid_x_end", 32'(x_crop_end_out), 1280);
    chk("rst_mid_y_start", 32'(y_crop_start_out), 0);
    chk("rst_mid_y_end", 32'(y_crop_end_out), 720);
    chk("rst_mid_addr", 32'(read_address_out), 0);
    chk("rst_mid_cap", 32'(capture_start_out), 0);
    frame_valid_in = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1;
    start_cap(0);
    end_cap(-1);
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/image_capture_ctrl.md
IMAGE_CAPTURE_CTRL -- requirements
Module: image_capture_ctrl

Interface
REQ-001 SHALL have parameter SENSOR_X_SIZE, default 1280, sensor width in pixels.
REQ-002 SHALL have parameter SENSOR_Y_SIZE, default 720, sensor height in lines.
REQ-003 SHALL have parameter ADDR_BITS, default 16, image buffer byte-address width.
REQ-004 SHALL have one clock and an asynchronous, active-low reset, named as follows:
- clock_spi_in  in  1  sole clock (72MHz).
- reset_spi_n_in  in  1  asynchronous, active-low reset.
REQ-005 SHALL have the following host-side ports:
- op_code_in  in  8  opcode.
- op_code_valid_in  in  1  opcode valid.
- operand_in  in  8  operand byte.
- operand_valid_in  in  1  operand valid.
- operand_count_in  in  32  operand index.
- response_out  out  8  response byte.
- response_valid_out  out  1  response valid.
REQ-006 SHALL have the following pipeline-side ports:
- frame_valid_in  in  1  asynchronous OR of pipeline frame_valid.
- image_size_in  in  20  encoded/RGB byte count.
- image_valid_in  in  1  image complete.
- read_data_in  in  8  buffer read data.
- read_address_out  out  ADDR_BITS  buffer read address.
REQ-007 SHALL have the following control-output ports:
- capture_start_out  out  1  one-cycle capture pulse.
- buffer_clear_out  out  1  one-cycle buffer/CDC clear.
- x_crop_start_out, x_crop_end_out  out  11 each  crop columns.
- y_crop_start_out, y_crop_end_out  out  10 each  crop lines.
- x_size_out  out  11  x_end-x_start-2.
- y_size_out  out  10  y_end-y_start-2.
- jpeg_sel_out  out  1  1=JPEG, 0=RGB.
- busy_out  out  1  capture in progress.

Function
REQ-008 SHALL pass frame_valid_in through a 2-flop synchroniser; fv_s denotes the synchronised value.
REQ-009 SHALL run FSM IDLE->ARM->WAIT_SOF->ACTIVE->IDLE; busy_out=1 in every state but IDLE.
REQ-010 IDLE: on opcode 0x20 with fv_s=0, SHALL go to WAIT_SOF and pulse capture_start_out and buffer_clear_out together for one cycle.
REQ-011 IDLE: on opcode 0x20 with fv_s=1, SHALL go to ARM; on fv_s=0 in ARM, SHALL pulse both outputs and go to WAIT_SOF.
REQ-012 SHALL leave WAIT_SOF for ACTIVE on fv_s rising, and ACTIVE for IDLE on fv_s falling.
REQ-013 SHALL ignore opcode 0x20 when not in IDLE and set status bit err_busy.
REQ-014 SHALL stage crop window writes (opcode 0x24) by operand_count_in: 0/1 x_start lo/hi, 2/3 x_end lo/hi, 4/5 y_start lo/hi, 6/7 y_end lo/hi.
REQ-015 SHALL commit staged values to the crop outputs on op_code_valid_in falling after 0x24, only if all hold: x_end>=x_start+4, y_end>=y_start+4, x_end<=SENSOR_X_SIZE, y_end<=SENSOR_Y_SIZE, state=IDLE.
REQ-016 SHALL keep the previous window and set err_window when a 0x24 commit is rejected.
REQ-017 SHALL drive x_size_out/y_size_out combinationally from the committed window, without underflow (guaranteed by REQ-015).
REQ-018 SHALL handle opcode 0x30 as follows: on operand_valid_in, jpeg_sel_out<=~operand_in[0] (operand 1=RGB); the write is ignored unless IDLE.
REQ-019 SHALL handle opcode 0x31 by returning image_size_in bytes 0/1/2 (bits 19:16 zero-extended) for operand_count 0/1/2; it returns 0 if image_valid_in=0.
REQ-020 SHALL handle opcode 0x32 (status) by returning {4'b0, err_window, err_busy, image_valid_in, busy_out}; the read clears both error bits on op_code_valid_in falling.
REQ-021 SHALL handle opcode 0x23 by loading read_address_out with operands 0/1 (lo/hi; bits above ADDR_BITS dropped).
REQ-022 SHALL handle opcode 0x22 by driving response_out<=read_data_in and incrementing read_address_out on each operand_valid_in rising edge.
REQ-023 SHALL saturate read_address_out at 2^ADDR_BITS-1 (no wrap).
REQ-024 SHALL reset read_address_out to 0 on an accepted capture.
REQ-025 SHALL register response_valid_out: 1 the cycle after op_code_valid_in=1 for opcodes 0x22/0x31/0x32, 0 otherwise; unknown opcodes give no response.

Reset
REQ-026 SHALL asynchronously return all outputs to reset values while reset_spi_n_in=0:
- response_out=0, response_valid_out=0.
- capture_start_out=0, buffer_clear_out=0.
- read_address_out=0, busy_out=0.
- jpeg_sel_out=1.
- window 0..SENSOR_X_SIZE / 0..SENSOR_Y_SIZE.
- error bits 0, FSM IDLE, synchroniser 0.
REQ-027 SHALL apply reset mid-capture (ARM/WAIT_SOF/ACTIVE) to force IDLE with no capture_start_out pulse; the first clock after release shall act as IDLE.

Structure
REQ-028 SHALL place opcode constants (0x20,0x22,0x23,0x24,0x30,0x31,0x32), the FSM state enum and the status bit positions in shared package camera_pkg.
REQ-029 SHALL implement the 2-flop frame_valid synchroniser as sub-module sync_2ff; everything else is flat.

Verification
REQ-030 SHALL cover: fv low, 0x20 -> start/clear pulse next cycle, busy=1; fv 0->1->0 -> IDLE, busy=0.
REQ-031 SHALL cover: fv high, 0x20 -> ARM, no pulse; fv falls -> pulse within 3 cycles, WAIT_SOF.
REQ-032 SHALL cover: 0x24 with 8,0,200,0,4,0,100,0 -> x_size=190, y_size=94; then x_end=1281 -> window unchanged, status bit3=1, cleared after read.
REQ-033 SHALL cover: 0x23 0xFE,0xFF then 0x22 with 4 operand strobes -> addresses FFFE, FFFF, FFFF, FFFF.
REQ-034 SHALL cover: image_size_in=0x12345, image_valid_in=1, 0x31 -> 0x45, 0x23, 0x01; with image_valid_in=0 -> 0, 0, 0.
REQ-035 SHALL cover: reset asserted in ACTIVE -> busy_out=0 immediately, jpeg_sel_out=1, window full-sensor.
